// File: rtl/instr_memory.sv
// Purpose : word-organised instruction ROM/RAM feeding the decoder; returns mem[PC[31:2]] on a registered output.
// Latency : one cycle from PC to Instruction_Code/Addr_Err; a write becomes visible on the following fetch.
// Backpr. : none; a fetch is accepted every cycle and writes complete in one cycle, no stall path.
//
// Ports:
//   CLK              rising-edge clock
//   RST              asynchronous active-low reset; restores the default program image
//   PC               byte address to fetch (bits [1:0] flag misalignment only)
//   Write_Enable     one-cycle pulse writes Write_Data to word Write_Addr[31:2]
//   Write_Addr       byte address of the write (bits [1:0] ignored)
//   Write_Data       instruction word to store
//   Instruction_Code registered instruction word at PC (NOP_WORD when out of range)
//   Addr_Err         registered flag: last fetch was out of range or misaligned
module instr_memory #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic        Write_Enable,
  input  logic [31:0] Write_Addr,
  input  logic [31:0] Write_Data,
  output logic [31:0] Instruction_Code,
  output logic        Addr_Err
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  // Default program: x1=5, x2=3, x3=x1+x2, x4=x1-x2, then NOP filler.
  function automatic logic [31:0] default_word(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'h00500093;
      1:       w = 32'h00300113;
      2:       w = 32'h002081B3;
      3:       w = 32'h40208233;
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      mem_d [DEPTH_WORDS];
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;

  logic             fetch_in_range;
  logic [IDX_W-1:0] fetch_idx;
  logic             wr_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             unused_waddr_lsb;

  // Range checks use the full 30-bit word index so that high address bits
  // cannot alias back into the array.
  assign fetch_in_range   = (PC[31:2] < DEPTH_IDX);
  assign fetch_idx        = PC[IDX_W+1:2];
  assign wr_in_range      = (Write_Addr[31:2] < DEPTH_IDX);
  assign wr_idx           = Write_Addr[IDX_W+1:2];
  assign wr_en            = Write_Enable && wr_in_range;
  assign unused_waddr_lsb = ^Write_Addr[1:0];

  // Fetch path reads the current array contents, so a same-cycle write to
  // the fetched word is not seen until the next fetch (read-before-write).
  always_comb begin
    instr_d = NOP_WORD;
    err_d   = 1'b1;
    if (fetch_in_range) begin
      instr_d = mem_q[fetch_idx];
      err_d   = (PC[1:0] != 2'b00);
    end
  end

  // Out-of-range writes are dropped here and never reach Addr_Err.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = Write_Data;
    end
  end

  // Reset reloads the whole image, so any patched words revert immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_q <= 32'h00000000;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= default_word(i);
      end
    end else begin
      instr_q <= instr_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign Instruction_Code = instr_q;
  assign Addr_Err         = err_q;

endmodule

// File: tb/tb_instr_memory.sv
module tb_instr_memory;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic        Write_Enable;
  logic [31:0] Write_Addr;
  logic [31:0] Write_Data;
  logic [31:0] Instruction_Code;
  logic        Addr_Err;

  instr_memory #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .PC               (PC),
    .Write_Enable     (Write_Enable),
    .Write_Addr       (Write_Addr),
    .Write_Data       (Write_Data),
    .Instruction_Code (Instruction_Code),
    .Addr_Err         (Addr_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input string n, input logic [31:0] pc, input logic we,
                              input logic [31:0] wa, input logic [31:0] wd,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.name = n; v.pc = pc; v.we = we; v.waddr = wa; v.wdata = wd;
    v.exp_instr = ei; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic check32(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  task automatic check1(input string n, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", n, act, exp);
    end
  endtask

  // Drive one fetch (and optional write) away from the edge, push the
  // expectation, then pop and compare once the registered output updates.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge CLK);
    PC           = v.pc;
    Write_Enable = v.we;
    Write_Addr   = v.waddr;
    Write_Data   = v.wdata;
    e.name = v.name; e.instr = v.exp_instr; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check32({e.name, "_instr"}, Instruction_Code, e.instr);
      check1({e.name, "_err"}, Addr_Err, e.err);
    end
  endtask

  initial begin
    // Vector table: expected values come from the default image written out by hand.
    add("pc0",        32'd0,   1'b0, 32'd0,   32'd0,        32'h00500093, 1'b0);
    add("pc4",        32'd4,   1'b0, 32'd0,   32'd0,        32'h00300113, 1'b0);
    add("pc8",        32'd8,   1'b0, 32'd0,   32'd0,        32'h002081B3, 1'b0);
    add("pc12",       32'd12,  1'b0, 32'd0,   32'd0,        32'h40208233, 1'b0);
    add("pc256_oor",  32'd256, 1'b0, 32'd0,   32'd0,        NOP,          1'b1);
    add("pc16_fill",  32'd16,  1'b0, 32'd0,   32'd0,        NOP,          1'b0);
    add("pc6_mis",    32'd6,   1'b0, 32'd0,   32'd0,        32'h00300113, 1'b1);
    add("pc252_last", 32'd252, 1'b0, 32'd0,   32'd0,        NOP,          1'b0);
    add("pc255_mis",  32'd255, 1'b0, 32'd0,   32'd0,        NOP,          1'b1);
    add("pc_high",    32'hFFFFFFFC, 1'b0, 32'd0, 32'd0,     NOP,          1'b1);
    add("wr8_old",    32'd8,   1'b1, 32'd8,   32'hDEADBEEF, 32'h002081B3, 1'b0);
    add("wr8_new",    32'd8,   1'b0, 32'd0,   32'd0,        32'hDEADBEEF, 1'b0);
    add("wr_oor",     32'd0,   1'b1, 32'd256, 32'hCAFEF00D, 32'h00500093, 1'b0);
    add("wr_mis_old", 32'd12,  1'b1, 32'd14,  32'h12345678, 32'h40208233, 1'b0);
    add("wr_mis_new", 32'd12,  1'b0, 32'd0,   32'd0,        32'h12345678, 1'b0);
    add("pc0_intact", 32'd0,   1'b0, 32'd0,   32'd0,        32'h00500093, 1'b0);
    add("pc256_err",  32'd256, 1'b0, 32'd0,   32'd0,        NOP,          1'b1);

    // Reset held 20 ns with PC left undriven.
    RST          = 1'b0;
    Write_Enable = 1'b0;
    Write_Addr   = 32'd0;
    Write_Data   = 32'd0;
    #12;
    check32("reset_instr", Instruction_Code, 32'h00000000);
    check1("reset_err", Addr_Err, 1'b0);
    #8;
    RST = 1'b1;
    #2;
    check32("post_release_instr", Instruction_Code, 32'h00000000);

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-cycle: output clears without a clock edge.
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check32("async_rst_instr", Instruction_Code, 32'h00000000);
    check1("async_rst_err", Addr_Err, 1'b0);

    // A write attempted while reset is held must be ignored.
    @(negedge CLK);
    PC           = 32'd8;
    Write_Enable = 1'b1;
    Write_Addr   = 32'd8;
    Write_Data   = 32'hBAD0BAD0;
    @(posedge CLK);
    #1;
    check32("rst_hold_instr", Instruction_Code, 32'h00000000);
    @(negedge CLK);
    Write_Enable = 1'b0;
    RST          = 1'b1;

    // Patched words must be back to the default image.
    begin
      vec_t v;
      v.name = "restored8";  v.pc = 32'd8;  v.we = 1'b0; v.waddr = 32'd0; v.wdata = 32'd0;
      v.exp_instr = 32'h002081B3; v.exp_err = 1'b0;
      apply(v);
      v.name = "restored12"; v.pc = 32'd12;
      v.exp_instr = 32'h40208233;
      apply(v);
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_memory.md
Name: instr_memory

Overview:
- Word-organised instruction memory for the single-cycle RISC-V CPU. It returns the 32-bit instruction at byte address PC on a registered output.
- Holds a fixed default program image. The image is restored on reset.
- Has an optional word-write port so a bench or loader can patch program contents.
- Sits between the PC register and the decoder.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit instruction words; valid byte range is 0 to 4*DEPTH_WORDS-1.
- NOP_WORD, 32'h00000013, filler and out-of-range return value (addi x0,x0,0).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- PC  input  32  byte address of the instruction to fetch.
- Write_Enable  input  1  high for one cycle writes Write_Data to the word at Write_Addr.
- Write_Addr  input  32  byte address for writes; bits [1:0] ignored.
- Write_Data  input  32  instruction word to store.
- Instruction_Code  output  32  registered instruction word at PC.
- Addr_Err  output  1  registered flag: last fetched PC was out of range or misaligned.

Behaviour:
- Word index = PC[31:2]. A fetch is in range when the word index < DEPTH_WORDS.
- Default image:
  - word0 = 32'h00500093 (addi x1,x0,5)
  - word1 = 32'h00300113 (addi x2,x0,3)
  - word2 = 32'h002081B3 (add x3,x1,x2)
  - word3 = 32'h40208233 (sub x4,x1,x2)
  - all remaining words = NOP_WORD
- Reset:
  - While RST=0, independent of CLK: Instruction_Code = 32'h00000000, Addr_Err = 0, and all memory words are forced to the default image.
  - Writes are ignored while RST=0.
  - Deassertion is sampled normally; the first fetch occurs on the first rising CLK edge with RST=1.
- Fetch: on each rising CLK edge with RST=1, Instruction_Code <= mem[PC[31:2]]. Latency is one cycle from PC to output.
- Out of range (word index >= DEPTH_WORDS): Instruction_Code <= NOP_WORD, Addr_Err <= 1.
- Misaligned PC (PC[1:0] != 0): fetch uses the word index (low bits dropped), Addr_Err <= 1.
- In-range, aligned fetch: Addr_Err <= 0.
- Write: on a rising CLK edge with RST=1 and Write_Enable=1, mem[Write_Addr[31:2]] <= Write_Data when the index is in range. Out-of-range writes are dropped silently and do not affect Addr_Err.
- Same-cycle write and fetch to the same word: the fetch returns the old contents (read-before-write). The new value is visible on the next fetch.
- PC unknown/undriven before the first edge after reset: the output must not be relied upon until PC is driven. Reset value 0 holds until the first sampled edge.
- Reset asserted mid-operation: the output clears to 0 immediately and all patched words revert to the default image.

Test Plan:
- RST=0 for 20 ns, then RST=1 with PC undriven -> Instruction_Code = 32'h00000000 and Addr_Err = 0 during reset.
- After reset, PC = 0, 4, 8, 12 on successive cycles -> Instruction_Code = 00500093, 00300113, 002081B3, 40208233, each one edge after PC is applied, Addr_Err = 0.
- PC = 4*DEPTH_WORDS (256) -> Instruction_Code = 00000013, Addr_Err = 1. Then PC = 16 -> 00000013 (filler), Addr_Err = 0.
- PC = 6 -> Instruction_Code = 00300113 (word1), Addr_Err = 1.
- Write_Enable=1, Write_Addr=8, Write_Data=DEADBEEF while PC=8 -> that edge outputs 002081B3; next edge with PC=8 outputs DEADBEEF.
- After the patch, pulse RST low asynchronously mid-cycle -> output is 0 at once. After release, PC=8 -> 002081B3 (image restored).
